// File: rtl/servant_pkg.sv
// rtl/servant_pkg.sv - shared region codes, register offsets and byte-lane helper
package servant_pkg;

   typedef enum logic [1:0] {
      REGION_MEM   = 2'b00,
      REGION_GPIO  = 2'b01,
      REGION_TIMER = 2'b10,
      REGION_NONE  = 2'b11
   } region_e;

   localparam logic [1:0] OFF_GPIO_OUT = 2'd0;
   localparam logic [1:0] OFF_GPIO_IN  = 2'd1;
   localparam logic [1:0] OFF_MTIME    = 2'd0;
   localparam logic [1:0] OFF_MTIMECMP = 2'd1;
   localparam logic [1:0] OFF_CTRL     = 2'd2;

   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_RUN    = 1;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/servant_periph_timer.sv
// rtl/servant_periph_timer.sv - MTIME/MTIMECMP/CTRL machine timer with registered compare irq
module servant_periph_timer
   import servant_pkg::*;
#(
   parameter int TIMER_W = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we_time,
   input  logic        i_we_cmp,
   input  logic        i_we_ctrl,
   input  logic [3:0]  i_sel,
   input  logic [31:0] i_dat,
   output logic [31:0] o_mtime,
   output logic [31:0] o_mtimecmp,
   output logic [1:0]  o_ctrl,
   output logic        o_irq
);

   localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

   logic [TIMER_W-1:0] r_mtime;
   logic [TIMER_W-1:0] r_cmp;
   logic [1:0]         r_ctrl;
   logic               r_irq;

   logic [31:0]        w_time32;
   logic [31:0]        w_cmp32;
   logic [31:0]        w_time_wr;
   logic [31:0]        w_cmp_wr;
   logic [TIMER_W-1:0] w_diff;

   always_comb begin
      w_time32                = '0;
      w_time32[TIMER_W-1:0]   = r_mtime;
      w_cmp32                 = '0;
      w_cmp32[TIMER_W-1:0]    = r_cmp;
   end

   assign w_time_wr = byte_merge(w_time32, i_dat, i_sel);
   assign w_cmp_wr  = byte_merge(w_cmp32, i_dat, i_sel);
   // Wrap-safe "reached": the difference is non-negative when its MSB is clear.
   assign w_diff    = r_mtime - r_cmp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mtime <= '0;
         r_cmp   <= '1;
         r_ctrl  <= '0;
         r_irq   <= 1'b0;
      end else begin
         if (i_we_time) begin
            r_mtime <= w_time_wr[TIMER_W-1:0];
         end else if (r_ctrl[CTRL_RUN]) begin
            r_mtime <= r_mtime + ONE;
         end
         if (i_we_cmp) begin
            r_cmp <= w_cmp_wr[TIMER_W-1:0];
         end
         if (i_we_ctrl && i_sel[0]) begin
            r_ctrl <= i_dat[1:0];
         end
         r_irq <= r_ctrl[CTRL_IRQ_EN] & ~w_diff[TIMER_W-1];
      end
   end

   assign o_mtime    = w_time32;
   assign o_mtimecmp = w_cmp32;
   assign o_ctrl     = r_ctrl;
   assign o_irq      = r_irq;

endmodule

// File: rtl/servant_periph_mux.sv
// rtl/servant_periph_mux.sv - CPU bus decoder: memory pass-through, GPIO, timer, unmapped
module servant_periph_mux
   import servant_pkg::*;
#(
   parameter int GPIO_W     = 8,
   parameter int TIMER_W    = 32,
   parameter int WITH_TIMER = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [31:0]       i_wb_cpu_adr,
   input  logic [31:0]       i_wb_cpu_dat,
   input  logic [3:0]        i_wb_cpu_sel,
   input  logic              i_wb_cpu_we,
   input  logic              i_wb_cpu_cyc,
   output logic [31:0]       o_wb_cpu_rdt,
   output logic              o_wb_cpu_ack,
   output logic [31:0]       o_wb_mem_adr,
   output logic [31:0]       o_wb_mem_dat,
   output logic [3:0]        o_wb_mem_sel,
   output logic              o_wb_mem_we,
   output logic              o_wb_mem_cyc,
   input  logic [31:0]       i_wb_mem_rdt,
   input  logic              i_wb_mem_ack,
   output logic [GPIO_W-1:0] o_gpio,
   input  logic [GPIO_W-1:0] i_gpio,
   output logic              o_timer_irq
);

   region_e           w_region;
   logic [1:0]        w_off;
   logic              w_mem_hit;
   logic              w_wr;
   logic              w_tmr_wr;
   logic [31:0]       w_rd_data;

   logic              r_ack;
   logic [31:0]       r_rdt;
   logic [GPIO_W-1:0] r_gpio;
   logic [GPIO_W-1:0] r_sync1;
   logic [GPIO_W-1:0] r_sync2;
   logic [GPIO_W-1:0] w_gpio_nxt;
   logic [31:0]       w_gpio_out32;
   logic [31:0]       w_gpio_in32;

   logic [31:0]       w_tmr_time;
   logic [31:0]       w_tmr_cmp;
   logic [1:0]        w_tmr_ctrl;
   logic              w_tmr_irq;

   assign w_region  = region_e'(i_wb_cpu_adr[31:30]);
   assign w_off     = i_wb_cpu_adr[3:2];
   assign w_mem_hit = (w_region == REGION_MEM);

   assign o_wb_mem_adr = i_wb_cpu_adr;
   assign o_wb_mem_dat = i_wb_cpu_dat;
   assign o_wb_mem_sel = i_wb_cpu_sel;
   assign o_wb_mem_we  = i_wb_cpu_we;
   assign o_wb_mem_cyc = i_wb_cpu_cyc & w_mem_hit;

   // Peripheral ack is masked by reset so a transaction interrupted by reset never completes.
   assign o_wb_cpu_ack = w_mem_hit ? i_wb_mem_ack : (r_ack & ~i_rst);
   assign o_wb_cpu_rdt = w_mem_hit ? i_wb_mem_rdt : r_rdt;

   assign w_wr     = i_wb_cpu_cyc & i_wb_cpu_we & r_ack & ~w_mem_hit;
   assign w_tmr_wr = w_wr & (w_region == REGION_TIMER);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack <= 1'b0;
      end else begin
         r_ack <= i_wb_cpu_cyc & ~w_mem_hit & ~r_ack;
      end
   end

   always_ff @(posedge i_clk) begin
      r_rdt <= w_rd_data;
   end

   always_comb begin
      w_gpio_nxt = r_gpio;
      for (int i = 0; i < GPIO_W; i++) begin
         if (i_wb_cpu_sel[i/8]) begin
            w_gpio_nxt[i] = i_wb_cpu_dat[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gpio  <= '0;
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_gpio;
         r_sync2 <= r_sync1;
         if (w_wr && (w_region == REGION_GPIO) && (w_off == OFF_GPIO_OUT)) begin
            r_gpio <= w_gpio_nxt;
         end
      end
   end

   assign o_gpio = r_gpio;

   always_comb begin
      w_gpio_out32               = '0;
      w_gpio_out32[GPIO_W-1:0]   = r_gpio;
      w_gpio_in32                = '0;
      w_gpio_in32[GPIO_W-1:0]    = r_sync2;
   end

   generate
      if (WITH_TIMER != 0) begin : g_timer
         servant_periph_timer #(
            .TIMER_W(TIMER_W)
         ) u_timer (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_we_time  (w_tmr_wr && (w_off == OFF_MTIME)),
            .i_we_cmp   (w_tmr_wr && (w_off == OFF_MTIMECMP)),
            .i_we_ctrl  (w_tmr_wr && (w_off == OFF_CTRL)),
            .i_sel      (i_wb_cpu_sel),
            .i_dat      (i_wb_cpu_dat),
            .o_mtime    (w_tmr_time),
            .o_mtimecmp (w_tmr_cmp),
            .o_ctrl     (w_tmr_ctrl),
            .o_irq      (w_tmr_irq)
         );
      end else begin : g_no_timer
         assign w_tmr_time = '0;
         assign w_tmr_cmp  = '0;
         assign w_tmr_ctrl = '0;
         assign w_tmr_irq  = 1'b0;
      end
   endgenerate

   assign o_timer_irq = w_tmr_irq;

   always_comb begin
      w_rd_data = '0;
      case (w_region)
         REGION_GPIO: begin
            if (w_off == OFF_GPIO_OUT) begin
               w_rd_data = w_gpio_out32;
            end else if (w_off == OFF_GPIO_IN) begin
               w_rd_data = w_gpio_in32;
            end
         end
         REGION_TIMER: begin
            if (w_off == OFF_MTIME) begin
               w_rd_data = w_tmr_time;
            end else if (w_off == OFF_MTIMECMP) begin
               w_rd_data = w_tmr_cmp;
            end else if (w_off == OFF_CTRL) begin
               w_rd_data = {30'd0, w_tmr_ctrl};
            end
         end
         default: w_rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_servant_periph_mux.sv
// tb/tb_servant_periph_mux.sv - directed vector bench for servant_periph_mux
module tb_servant_periph_mux;

   logic        clk;
   logic        rst;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic        we, cyc;
   logic [31:0] mem_rdt_in;
   logic        mem_ack_in;
   logic [7:0]  gpio_in;

   logic [31:0] rdt, mem_adr, mem_dat;
   logic [3:0]  mem_sel;
   logic        ack, mem_we, mem_cyc, irq;
   logic [7:0]  gpio_out;

   logic [31:0] rdt_nt, mem_adr_nt, mem_dat_nt;
   logic [3:0]  mem_sel_nt;
   logic        ack_nt, mem_we_nt, mem_cyc_nt, irq_nt;
   logic [7:0]  gpio_out_nt;

   int total = 0;
   int bad   = 0;

   servant_periph_mux #(.GPIO_W(8), .TIMER_W(8), .WITH_TIMER(1)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel),
      .i_wb_cpu_we(we), .i_wb_cpu_cyc(cyc),
      .o_wb_cpu_rdt(rdt), .o_wb_cpu_ack(ack),
      .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
      .o_wb_mem_we(mem_we), .o_wb_mem_cyc(mem_cyc),
      .i_wb_mem_rdt(mem_rdt_in), .i_wb_mem_ack(mem_ack_in),
      .o_gpio(gpio_out), .i_gpio(gpio_in), .o_timer_irq(irq)
   );

   servant_periph_mux #(.GPIO_W(8), .TIMER_W(8), .WITH_TIMER(0)) dut_nt (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel),
      .i_wb_cpu_we(we), .i_wb_cpu_cyc(cyc),
      .o_wb_cpu_rdt(rdt_nt), .o_wb_cpu_ack(ack_nt),
      .o_wb_mem_adr(mem_adr_nt), .o_wb_mem_dat(mem_dat_nt), .o_wb_mem_sel(mem_sel_nt),
      .o_wb_mem_we(mem_we_nt), .o_wb_mem_cyc(mem_cyc_nt),
      .i_wb_mem_rdt(mem_rdt_in), .i_wb_mem_ack(mem_ack_in),
      .o_gpio(gpio_out_nt), .i_gpio(gpio_in), .o_timer_irq(irq_nt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      logic        chk_rdt;
      logic [31:0] exp_rdt;
      logic [7:0]  exp_gpio;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output logic [31:0] r, output logic [31:0] r_nt,
                       output int lat, output logic ack_after);
      @(negedge clk);
      adr = a; dat = d; sel = s; we = w; cyc = 1'b1;
      lat = 0;
      r = '0;
      r_nt = '0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack && lat < 8);
      r    = rdt;
      r_nt = rdt_nt;
      @(posedge clk); #1;
      ack_after = ack;
      cyc = 1'b0; we = 1'b0;
   endtask

   initial begin
      logic [31:0] r, r_nt;
      int          lat;
      logic        ack_after;

      vecs[0]  = '{32'h4000_0000, 32'h0000_00A5, 4'b0001, 1'b1, 1'b0, 32'h0,          8'hA5};
      vecs[1]  = '{32'h4000_0000, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0000_00A5, 8'hA5};
      vecs[2]  = '{32'h4000_0000, 32'h0000_FF3C, 4'b0010, 1'b1, 1'b0, 32'h0,          8'hA5};
      vecs[3]  = '{32'h4000_0000, 32'h1234_5678, 4'b0001, 1'b1, 1'b0, 32'h0,          8'h78};
      vecs[4]  = '{32'h4000_0000, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0000_0078, 8'h78};
      vecs[5]  = '{32'h4000_0000, 32'h0000_00FF, 4'b0000, 1'b1, 1'b0, 32'h0,          8'h78};
      vecs[6]  = '{32'h4000_0004, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0000_003C, 8'h78};
      vecs[7]  = '{32'h4000_0004, 32'h0,         4'b1111, 1'b1, 1'b0, 32'h0,          8'h78};
      vecs[8]  = '{32'hC000_0000, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0,          8'h78};
      vecs[9]  = '{32'hC000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, 32'h0,          8'h78};
      vecs[10] = '{32'h8000_000C, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0,          8'h78};
      vecs[11] = '{32'h8000_0008, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0,          8'h78};
      vecs[12] = '{32'h8000_0004, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0000_00FF, 8'h78};
      vecs[13] = '{32'h8000_0000, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0,          8'h78};
      vecs[14] = '{32'h8000_0004, 32'h0000_1234, 4'b0011, 1'b1, 1'b0, 32'h0,          8'h78};
      vecs[15] = '{32'h8000_0004, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0000_0034, 8'h78};
      vecs[16] = '{32'h8000_0004, 32'h0000_AB00, 4'b0010, 1'b1, 1'b0, 32'h0,          8'h78};
      vecs[17] = '{32'h8000_0004, 32'h0,         4'b1111, 1'b0, 1'b1, 32'h0000_0034, 8'h78};

      rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0;
      mem_rdt_in = '0; mem_ack_in = 1'b0; gpio_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_gpio", 32'(gpio_out), 32'h0);
      check("reset_ack", 32'(ack), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_mem_cyc", 32'(mem_cyc), 32'h0);

      gpio_in = 8'h3C;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 18; i++) begin
         xfer(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, r, r_nt, lat, ack_after);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
         check($sformatf("v%0d_single_ack", i), 32'(ack_after), 32'h0);
         check($sformatf("v%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
         if (vecs[i].chk_rdt) begin
            check($sformatf("v%0d_rdt", i), r, vecs[i].exp_rdt);
         end
      end

      // Timer wrap: irq rises 33 samples after MTIME is loaded with 0xF0 against CMP 0x10.
      xfer(32'h8000_0008, 32'h3, 4'b0001, 1'b1, r, r_nt, lat, ack_after);
      xfer(32'h8000_0004, 32'h10, 4'b0001, 1'b1, r, r_nt, lat, ack_after);
      xfer(32'h8000_0000, 32'hF0, 4'b0001, 1'b1, r, r_nt, lat, ack_after);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         check($sformatf("irq_wrap_k%0d", k), 32'(irq), (k >= 33) ? 32'h1 : 32'h0);
      end
      check("no_timer_irq", 32'(irq_nt), 32'h0);
      xfer(32'h8000_0004, 32'h80, 4'b0001, 1'b1, r, r_nt, lat, ack_after);
      @(posedge clk); #1;
      check("irq_cleared_by_cmp", 32'(irq), 32'h0);
      xfer(32'h8000_0004, 32'h0, 4'b1111, 1'b0, r, r_nt, lat, ack_after);
      check("cmp_readback", r, 32'h80);
      check("no_timer_cmp_read", r_nt, 32'h0);
      xfer(32'h8000_0008, 32'h0, 4'b1111, 1'b0, r, r_nt, lat, ack_after);
      check("ctrl_readback", r, 32'h3);
      check("no_timer_ctrl_read", r_nt, 32'h0);
      check("no_timer_irq_end", 32'(irq_nt), 32'h0);

      // Memory pass-through with the slave acking on the third cycle.
      @(negedge clk);
      adr = 32'h0000_0100; dat = 32'h1122_3344; sel = 4'b0101; we = 1'b1; cyc = 1'b1;
      #1;
      check("mem_cyc", 32'(mem_cyc), 32'h1);
      check("mem_adr", mem_adr, 32'h0000_0100);
      check("mem_dat", mem_dat, 32'h1122_3344);
      check("mem_sel", 32'(mem_sel), 32'h5);
      check("mem_we", 32'(mem_we), 32'h1);
      we = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         if (c == 3) begin
            mem_ack_in = 1'b1; mem_rdt_in = 32'hDEAD_BEEF;
            #1;
            check("mem_ack_follow", 32'(ack), 32'h1);
            check("mem_rdt_follow", rdt, 32'hDEAD_BEEF);
         end else begin
            check($sformatf("mem_wait_c%0d", c), 32'(ack), 32'h0);
         end
      end
      @(posedge clk); #1;
      mem_ack_in = 1'b0; cyc = 1'b0;
      adr = 32'h4000_0000; cyc = 1'b1;
      #1;
      check("no_mem_cyc_gpio", 32'(mem_cyc), 32'h0);
      cyc = 1'b0;

      // Reset lands in the ack cycle of a GPIO write: no ack, no write.
      @(negedge clk);
      adr = 32'h4000_0000; dat = 32'h55; sel = 4'b0001; we = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_mid_ack", 32'(ack), 32'h0);
      @(posedge clk); #1;
      check("rst_mid_gpio", 32'(gpio_out), 32'h0);
      check("rst_mid_irq", 32'(irq), 32'h0);
      rst = 1'b0; cyc = 1'b0; we = 1'b0;
      xfer(32'h8000_0004, 32'h0, 4'b1111, 1'b0, r, r_nt, lat, ack_after);
      check("rst_cmp_ones", r, 32'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/servant_periph_mux.md
SERVANT_PERIPH_MUX -- requirements
Module: servant_periph_mux

Interface
REQ-001 Parameter GPIO_W, default 8, GPIO output/input width, legal range 1..32.
REQ-002 Parameter TIMER_W, default 32, timer counter/compare width, legal range 8..32.
REQ-003 Parameter WITH_TIMER, default 1; when 0 the timer is absent, timer reads return 0 and o_timer_irq is tied 0.
REQ-004 Ports: i_clk in 1 system clock; i_rst in 1 reset, synchronous, active-high; one clock domain only.
REQ-005 CPU data-bus slave: i_wb_cpu_adr in 32, i_wb_cpu_dat in 32, i_wb_cpu_sel in 4, i_wb_cpu_we in 1, i_wb_cpu_cyc in 1, o_wb_cpu_rdt out 32, o_wb_cpu_ack out 1.
REQ-006 Memory master: o_wb_mem_adr out 32, o_wb_mem_dat out 32, o_wb_mem_sel out 4, o_wb_mem_we out 1, o_wb_mem_cyc out 1, i_wb_mem_rdt in 32, i_wb_mem_ack in 1.
REQ-007 o_gpio out GPIO_W, registered output pins; i_gpio in GPIO_W, asynchronous input pins; o_timer_irq out 1, timer interrupt level.

Function
REQ-008 Decode on adr[31:30]: 00 memory, 01 GPIO, 10 timer, 11 unmapped; register offset is adr[3:2].
REQ-009 Memory region: adr/dat/sel/we pass through combinationally, o_wb_mem_cyc = i_wb_cpu_cyc & region hit, CPU ack/rdt taken from memory.
REQ-010 GPIO/timer/unmapped accesses: o_wb_cpu_ack pulses exactly one cycle, one cycle after cyc is first seen; no back-to-back ack while cyc stays high (ack register cleared the cycle after it fires).
REQ-011 Write side effects occur only on the cycle ack is asserted; only one write per transaction.
REQ-012 GPIO offset 0 (OUT): read/write; writes honour sel per byte; bits at or above GPIO_W are ignored and read 0.
REQ-013 GPIO offset 1 (IN): read-only; returns i_gpio after a two-flop synchroniser, zero-extended; writes ignored.
REQ-014 Timer offset 0 (MTIME): free-running TIMER_W counter, increments each cycle when CTRL.run=1, wraps to 0 after all-ones; a write loads the written value (byte sel honoured) with no increment that cycle.
REQ-015 Timer offset 1 (MTIMECMP): read/write, TIMER_W bits, byte sel honoured.
REQ-016 Timer offset 2 (CTRL): bit0 irq_en, bit1 run; other bits read 0.
REQ-017 o_timer_irq is registered: asserted when irq_en=1 and MSB of (MTIME - MTIMECMP) mod 2^TIMER_W is 0, i.e. wrap-safe "MTIME reached CMP"; it updates one cycle after any operand changes.
REQ-018 Writing MTIMECMP in the cycle MTIME equals the old compare: the new value governs o_timer_irq from the next cycle.
REQ-019 Unmapped region and timer offset 3: reads return 0, writes ignored, ack still given (no bus hang).
REQ-020 Read data for peripheral accesses is registered and valid in the ack cycle; o_wb_cpu_rdt is don't-care otherwise.

Reset
REQ-021 On i_rst: o_gpio=0, MTIME=0, MTIMECMP=all-ones, CTRL=0 (timer stopped, irq disabled), synchroniser flops=0, ack register=0, o_timer_irq=0.
REQ-022 Reset asserted mid-transaction drops any pending ack; the write is not performed; the CPU reissues after reset.
REQ-023 Memory-path signals are combinational and not reset.

Structure
REQ-024 Region codes (00/01/10/11) and register offsets live in a shared package servant_pkg as named constants.
REQ-025 Timer is a sub-module servant_periph_timer (MTIME, MTIMECMP, CTRL, irq), instantiated only when WITH_TIMER=1; decoding, ack and GPIO remain in the top.

Verification
REQ-026 Write 0xA5 sel=0001 to 0x4000_0000 with GPIO_W=8 -> ack one cycle later, single pulse; o_gpio=0xA5 next cycle; readback 0x0000_00A5.
REQ-027 Drive i_gpio=0x3C, wait 2 cycles, read 0x4000_0004 -> rdt=0x0000_003C; a write to the same address leaves o_gpio unchanged.
REQ-028 TIMER_W=8: write CTRL=3, MTIMECMP=0x10, MTIME=0xF0 -> irq low until MTIME reaches 0x10 after wrap, irq asserted one cycle later; writing MTIMECMP=0x80 deasserts it next cycle.
REQ-029 Memory access to 0x0000_0100 with memory ack delayed 3 cycles -> CPU ack coincides with i_wb_mem_ack, rdt equals i_wb_mem_rdt, no mem cyc for 0x4000_0000 accesses.
REQ-030 Read 0xC000_0000 -> ack after one cycle, rdt=0; assert i_rst the cycle after a GPIO write cyc rises -> no ack, o_gpio=0.
REQ-031 WITH_TIMER=0: timer reads return 0, o_timer_irq stays 0 after CTRL write of 3.
